// File: rtl/axi_wr_pkg.sv
// Shared codes and state type for the banked AXI4 write slave.
// Holds BRESP and AWBURST encodings plus the legal-WRAP-length check.
package axi_wr_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DATA      = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_RESP      = 2'd3
    } wr_state_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat address and beat counter for one AXI write burst.
// Loads the start address on the AW handshake and advances on each accepted beat.
module axi_burst_addr_gen
    import axi_wr_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_start_addr,
    input  logic [2:0]        i_size,
    input  logic [7:0]        i_len,
    input  logic [1:0]        i_burst,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_count,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_count;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_next;

    always_comb begin
        w_inc  = ADDR_W'(1) << i_size;
        w_mask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);
        w_next = r_addr + w_inc;
        case (i_burst)
            BURST_FIXED: w_next = r_addr;
            // WRAP keeps the aligned upper bits and wraps the low bits within the window
            BURST_WRAP:  w_next = (r_addr & ~w_mask) | ((r_addr + w_inc) & w_mask);
            default:     w_next = r_addr + w_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_addr  <= i_start_addr;
            r_count <= '0;
        end else if (i_advance) begin
            r_addr  <= w_next;
            r_count <= r_count + 8'd1;
        end
    end

    assign o_addr  = r_addr;
    assign o_count = r_count;
    assign o_last  = (r_count == i_len);

endmodule

// File: rtl/axi_wr_slave_bank.sv
// AXI4 write slave routing one burst at a time to one of N_TGT local write targets.
// state     | meaning: IDLE accept AW; DATA pass beats; WAIT_DONE await tgt_done; RESP hold B.
module axi_wr_slave_bank
    import axi_wr_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 11,
    parameter int ID_W    = 8,
    parameter int N_TGT   = 3,
    parameter int DONE_TO = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic [3:0]          AWREGION,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    output logic [N_TGT-1:0]    tgt_wr_vld,
    input  logic [N_TGT-1:0]    tgt_wr_rdy,
    output logic [ADDR_W-1:0]   tgt_wr_addr,
    output logic [DATA_W-1:0]   tgt_wr_data,
    output logic [DATA_W/8-1:0] tgt_wr_strb,
    output logic                tgt_wr_last,
    input  logic [N_TGT-1:0]    tgt_done,
    input  logic [N_TGT-1:0]    tgt_err,
    output logic                busy
);

    localparam int MAX_SIZE = $clog2(DATA_W / 8);
    localparam int TMR_W    = $clog2(DONE_TO + 1);

    wr_state_t         r_state;
    logic [ID_W-1:0]   r_id;
    logic [3:0]        r_sel;
    logic [2:0]        r_size;
    logic [7:0]        r_len;
    logic [1:0]        r_burst;
    logic              r_decerr;
    logic              r_slverr;
    logic              r_drain;
    logic [TMR_W-1:0]  r_timer;

    logic              w_run;
    logic              w_in_data;
    logic              w_aw_hs;
    logic              w_aw_decerr;
    logic              w_aw_slverr;
    logic              w_sel_rdy;
    logic              w_sel_done;
    logic              w_sel_err;
    logic [N_TGT-1:0]  w_vld;
    logic              w_beat;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_count;
    logic              w_last;

    // Outputs are forced quiet while rst is high, not only after the reset edge
    assign w_run     = ~rst;
    assign w_in_data = (r_state == S_DATA) & w_run;
    assign AWREADY   = (r_state == S_IDLE) & w_run;
    assign w_aw_hs   = AWVALID & AWREADY;

    assign w_aw_decerr = (int'(AWREGION) >= N_TGT);
    assign w_aw_slverr = (int'(AWSIZE) > MAX_SIZE) || (AWBURST == 2'b11) ||
                         ((AWBURST == BURST_WRAP) && !wrap_len_ok(AWLEN));

    always_comb begin
        w_sel_rdy  = 1'b0;
        w_sel_done = 1'b0;
        w_sel_err  = 1'b0;
        w_vld      = '0;
        for (int i = 0; i < N_TGT; i++) begin
            if (r_sel == 4'(i)) begin
                w_sel_rdy  = tgt_wr_rdy[i];
                w_sel_done = tgt_done[i];
                w_sel_err  = tgt_err[i];
                w_vld[i]   = w_in_data & ~r_drain & WVALID;
            end
        end
    end

    assign WREADY = w_in_data & (r_drain | w_sel_rdy);
    assign w_beat = WVALID & WREADY;

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_aw_hs),
        .i_start_addr (AWADDR),
        .i_size       (r_size),
        .i_len        (r_len),
        .i_burst      (r_burst),
        .i_advance    (w_beat),
        .o_addr       (w_addr),
        .o_count      (w_count),
        .o_last       (w_last)
    );

    assign tgt_wr_vld  = w_vld;
    assign tgt_wr_addr = w_run ? w_addr : '0;
    assign tgt_wr_data = WDATA;
    assign tgt_wr_strb = WSTRB;
    assign tgt_wr_last = w_in_data & ~r_drain & w_last;

    assign BVALID = (r_state == S_RESP) & w_run;
    assign BID    = BVALID ? r_id : '0;
    assign BRESP  = !BVALID ? RESP_OKAY   :
                    r_decerr ? RESP_DECERR :
                    r_slverr ? RESP_SLVERR : RESP_OKAY;
    assign busy   = (r_state != S_IDLE) & w_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_id     <= '0;
            r_sel    <= '0;
            r_size   <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_decerr <= 1'b0;
            r_slverr <= 1'b0;
            r_drain  <= 1'b0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        r_id     <= AWID;
                        r_sel    <= AWREGION;
                        r_size   <= AWSIZE;
                        r_len    <= AWLEN;
                        r_burst  <= AWBURST;
                        r_decerr <= w_aw_decerr;
                        r_slverr <= w_aw_slverr;
                        r_drain  <= w_aw_decerr | w_aw_slverr;
                        r_timer  <= '0;
                        r_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_sel_err) r_slverr <= 1'b1;
                    if (w_beat) begin
                        if (WLAST != w_last) r_slverr <= 1'b1;
                        // A done pulse is only meaningful on the final beat; earlier ones are dropped
                        if (w_last) r_state <= (r_drain | w_sel_done) ? S_RESP : S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (w_sel_err) r_slverr <= 1'b1;
                    r_timer <= r_timer + TMR_W'(1);
                    if (w_sel_done) begin
                        r_state <= S_RESP;
                    end else if (r_timer == TMR_W'(DONE_TO - 1)) begin
                        r_slverr <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (BREADY) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = ^w_count;

endmodule

// File: tb/tb_axi_wr_slave_bank.sv
// Directed bench for axi_wr_slave_bank: burst addressing, routing, errors, timeout, B hold, reset.
module tb_axi_wr_slave_bank;

    logic        clk;
    logic        rst;
    logic [7:0]  AWID;
    logic [10:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [3:0]  AWREGION;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [2:0]  tgt_wr_vld;
    logic [2:0]  tgt_wr_rdy;
    logic [10:0] tgt_wr_addr;
    logic [31:0] tgt_wr_data;
    logic [3:0]  tgt_wr_strb;
    logic        tgt_wr_last;
    logic [2:0]  tgt_done;
    logic [2:0]  tgt_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [10:0] obs_addr [16];
    logic [2:0]  obs_vld  [16];
    logic        obs_last [16];
    logic [31:0] obs_data [16];
    logic [3:0]  obs_strb [16];
    int          obs_cyc  [16];
    int          obs_n;
    bit          stall_ok;
    int          b_n;
    bit          b_got;
    logic [7:0]  b_id;
    logic [1:0]  b_resp;

    axi_wr_slave_bank #(
        .DATA_W (32), .ADDR_W (11), .ID_W (8), .N_TGT (3), .DONE_TO (8)
    ) dut (
        .clk (clk), .rst (rst),
        .AWID (AWID), .AWADDR (AWADDR), .AWLEN (AWLEN), .AWSIZE (AWSIZE),
        .AWBURST (AWBURST), .AWREGION (AWREGION), .AWVALID (AWVALID), .AWREADY (AWREADY),
        .WDATA (WDATA), .WSTRB (WSTRB), .WLAST (WLAST), .WVALID (WVALID), .WREADY (WREADY),
        .BID (BID), .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
        .tgt_wr_vld (tgt_wr_vld), .tgt_wr_rdy (tgt_wr_rdy), .tgt_wr_addr (tgt_wr_addr),
        .tgt_wr_data (tgt_wr_data), .tgt_wr_strb (tgt_wr_strb), .tgt_wr_last (tgt_wr_last),
        .tgt_done (tgt_done), .tgt_err (tgt_err), .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] onehot(input int sel);
        return (sel < 3) ? 3'(1 << sel) : 3'b000;
    endfunction

    task automatic do_aw(input logic [7:0] id, input logic [10:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [3:0] region);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWREGION = region;
        AWVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0;
    endtask

    // Offers n beats; records what the target side saw on each accepted beat.
    task automatic send_beats(input int n, input int sel, input int data0, input int wlast_at,
                              input int stall_at, input bit done_last);
        bit acc;
        int cyc;
        obs_n = 0;
        stall_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            WVALID = 1'b1;
            WDATA  = 32'(data0 + i);
            WSTRB  = 4'hF ^ 4'(i);
            WLAST  = (i == wlast_at);
            if (i == stall_at) begin
                tgt_wr_rdy = 3'b000;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    if (WREADY !== 1'b0 || tgt_wr_vld !== onehot(sel)) stall_ok = 1'b0;
                    @(posedge clk); #1;
                end
                tgt_wr_rdy = 3'b111;
            end
            tgt_done = (done_last && i == n - 1) ? onehot(sel) : 3'b000;
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (WREADY === 1'b1) begin
                    obs_addr[i] = tgt_wr_addr;
                    obs_vld[i]  = tgt_wr_vld;
                    obs_last[i] = tgt_wr_last;
                    obs_data[i] = tgt_wr_data;
                    obs_strb[i] = tgt_wr_strb;
                    acc = 1'b1;
                end
                @(posedge clk); #1;
            end
            obs_cyc[i] = cyc;
            if (!acc) break;
            obs_n++;
        end
        WVALID = 1'b0; WLAST = 1'b0; tgt_done = 3'b000;
    endtask

    // Counts negedges from the final beat until BVALID; optionally pulses tgt_done in cycle done_at.
    task automatic wait_b(input int sel, input int done_at, input int budget);
        b_n = 0; b_got = 1'b0; b_id = '0; b_resp = '0;
        while (!b_got && b_n < budget) begin
            tgt_done = (b_n + 1 == done_at) ? onehot(sel) : 3'b000;
            @(negedge clk);
            b_n++;
            if (BVALID === 1'b1) begin
                b_got = 1'b1; b_id = BID; b_resp = BRESP;
            end
            @(posedge clk); #1;
        end
        tgt_done = 3'b000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({AWREADY, WREADY, BVALID, tgt_wr_last, busy} !== 5'b0)
            begin errors++; $display("FAIL reset_ctrl got %b exp 00000", {AWREADY, WREADY, BVALID, tgt_wr_last, busy}); end
        checks++;
        if (tgt_wr_vld !== 3'b0 || BID !== 8'h0 || BRESP !== 2'b0 || tgt_wr_addr !== 11'h0)
            begin errors++; $display("FAIL reset_vals vld=%b bid=%h bresp=%b addr=%h exp 0", tgt_wr_vld, BID, BRESP, tgt_wr_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (AWREADY !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL reset_release awready=%b busy=%b exp 1 0", AWREADY, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_incr();
        logic [10:0] ea [4];
        ea = '{11'h000, 11'h004, 11'h008, 11'h00C};
        do_aw(8'd1, 11'h000, 8'd3, 3'd2, 2'b01, 4'd1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || AWREADY !== 1'b0)
            begin errors++; $display("FAIL incr_busy busy=%b awready=%b exp 1 0", busy, AWREADY); end
        @(posedge clk); #1;
        send_beats(4, 1, 10, 3, -1, 1'b0);
        checks++;
        if (obs_n !== 4) begin errors++; $display("FAIL incr_beats got %0d exp 4", obs_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_addr[i] !== ea[i] || obs_vld[i] !== 3'b010 || obs_last[i] !== (i == 3))
                begin errors++; $display("FAIL incr_beat%0d addr=%h vld=%b last=%b exp %h 010 %0d", i, obs_addr[i], obs_vld[i], obs_last[i], ea[i], (i == 3)); end
            checks++;
            if (obs_data[i] !== 32'(10 + i) || obs_strb[i] !== (4'hF ^ 4'(i)))
                begin errors++; $display("FAIL incr_data%0d got %0d/%h exp %0d/%h", i, obs_data[i], obs_strb[i], 10 + i, 4'hF ^ 4'(i)); end
        end
        wait_b(1, 1, 20);
        checks++;
        if (b_n !== 2 || b_id !== 8'd1 || b_resp !== 2'b00)
            begin errors++; $display("FAIL incr_b n=%0d bid=%h bresp=%b exp 2 01 00", b_n, b_id, b_resp); end
        @(negedge clk);
        checks++;
        if (AWREADY !== 1'b1) begin errors++; $display("FAIL incr_awready_after_b got %b exp 1", AWREADY); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_fixed();
        logic [10:0] ea [4];
        ea = '{11'h008, 11'h00C, 11'h000, 11'h004};
        do_aw(8'd2, 11'h008, 8'd3, 3'd2, 2'b10, 4'd0);
        send_beats(4, 0, 100, 3, -1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_addr[i] !== ea[i] || obs_vld[i] !== 3'b001)
                begin errors++; $display("FAIL wrap_beat%0d addr=%h vld=%b exp %h 001", i, obs_addr[i], obs_vld[i], ea[i]); end
        end
        wait_b(0, 0, 20);
        checks++;
        if (b_n !== 1 || b_resp !== 2'b00 || b_id !== 8'd2)
            begin errors++; $display("FAIL wrap_b n=%0d bresp=%b bid=%h exp 1 00 02", b_n, b_resp, b_id); end

        do_aw(8'd3, 11'h010, 8'd2, 3'd2, 2'b00, 4'd2);
        send_beats(3, 2, 200, 2, -1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_addr[i] !== 11'h010 || obs_vld[i] !== 3'b100)
                begin errors++; $display("FAIL fixed_beat%0d addr=%h vld=%b exp 010 100", i, obs_addr[i], obs_vld[i]); end
        end
        wait_b(2, 3, 20);
        checks++;
        if (b_n !== 4 || b_resp !== 2'b00)
            begin errors++; $display("FAIL fixed_b n=%0d bresp=%b exp 4 00", b_n, b_resp); end
    endtask

    task automatic test_drain();
        do_aw(8'd9, 11'h000, 8'd1, 3'd2, 2'b01, 4'd5);
        send_beats(2, 5, 50, 1, -1, 1'b0);
        checks++;
        if (obs_n !== 2) begin errors++; $display("FAIL decerr_beats got %0d exp 2", obs_n); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_cyc[i] !== 1 || obs_vld[i] !== 3'b000)
                begin errors++; $display("FAIL decerr_beat%0d cyc=%0d vld=%b exp 1 000", i, obs_cyc[i], obs_vld[i]); end
        end
        wait_b(5, 0, 20);
        checks++;
        if (b_n !== 1 || b_resp !== 2'b11 || b_id !== 8'd9)
            begin errors++; $display("FAIL decerr_b n=%0d bresp=%b bid=%h exp 1 11 09", b_n, b_resp, b_id); end

        do_aw(8'd4, 11'h000, 8'd0, 3'd3, 2'b01, 4'd0);
        send_beats(1, 0, 60, 0, -1, 1'b0);
        checks++;
        if (obs_n !== 1 || obs_vld[0] !== 3'b000)
            begin errors++; $display("FAIL badsize_beat n=%0d vld=%b exp 1 000", obs_n, obs_vld[0]); end
        wait_b(0, 0, 20);
        checks++;
        if (b_n !== 1 || b_resp !== 2'b10)
            begin errors++; $display("FAIL badsize_b n=%0d bresp=%b exp 1 10", b_n, b_resp); end
    endtask

    task automatic test_stall_wlast();
        do_aw(8'd5, 11'h020, 8'd3, 3'd2, 2'b01, 4'd0);
        send_beats(4, 0, 300, 3, 2, 1'b0);
        checks++;
        if (stall_ok !== 1'b1) begin errors++; $display("FAIL stall_wready got bad WREADY/vld during stall exp 0/001"); end
        checks++;
        if (obs_n !== 4 || obs_addr[2] !== 11'h028 || obs_data[2] !== 32'd302 || obs_addr[3] !== 11'h02C)
            begin errors++; $display("FAIL stall_beats n=%0d a2=%h d2=%0d a3=%h exp 4 028 302 02C", obs_n, obs_addr[2], obs_data[2], obs_addr[3]); end
        wait_b(0, 2, 20);
        checks++;
        if (b_resp !== 2'b00 || b_n !== 3)
            begin errors++; $display("FAIL stall_b n=%0d bresp=%b exp 3 00", b_n, b_resp); end

        do_aw(8'd6, 11'h200, 8'd3, 3'd2, 2'b01, 4'd1);
        send_beats(4, 1, 400, 1, -1, 1'b0);
        checks++;
        if (obs_n !== 4 || obs_addr[3] !== 11'h20C || obs_last[3] !== 1'b1 || obs_last[1] !== 1'b0)
            begin errors++; $display("FAIL wlast_beats n=%0d a3=%h l3=%b l1=%b exp 4 20C 1 0", obs_n, obs_addr[3], obs_last[3], obs_last[1]); end
        wait_b(1, 1, 20);
        checks++;
        if (b_resp !== 2'b10) begin errors++; $display("FAIL wlast_b bresp=%b exp 10", b_resp); end
    endtask

    task automatic test_timeout_err();
        do_aw(8'd7, 11'h004, 8'd0, 3'd2, 2'b01, 4'd1);
        send_beats(1, 1, 500, 0, -1, 1'b0);
        wait_b(1, 0, 30);
        checks++;
        if (b_n !== 9 || b_resp !== 2'b10 || b_id !== 8'd7)
            begin errors++; $display("FAIL timeout_b n=%0d bresp=%b bid=%h exp 9 10 07", b_n, b_resp, b_id); end

        do_aw(8'd8, 11'h040, 8'd1, 3'd2, 2'b01, 4'd2);
        tgt_err = 3'b100;
        send_beats(2, 2, 600, 1, -1, 1'b0);
        tgt_err = 3'b000;
        wait_b(2, 1, 20);
        checks++;
        if (b_n !== 2 || b_resp !== 2'b10)
            begin errors++; $display("FAIL tgterr_b n=%0d bresp=%b exp 2 10", b_n, b_resp); end
    endtask

    task automatic test_back_to_back_bready();
        bit stable;
        BREADY = 1'b0;
        do_aw(8'h5A, 11'h100, 8'd0, 3'd2, 2'b01, 4'd0);
        send_beats(1, 0, 700, 0, -1, 1'b1);
        wait_b(0, 0, 20);
        checks++;
        if (b_n !== 1 || b_id !== 8'h5A || b_resp !== 2'b00)
            begin errors++; $display("FAIL bhold_first n=%0d bid=%h bresp=%b exp 1 5a 00", b_n, b_id, b_resp); end
        stable = 1'b1;
        AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (BVALID !== 1'b1 || BID !== 8'h5A || BRESP !== 2'b00 || AWREADY !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        AWVALID = 1'b0;
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL bhold_stable B changed or AWREADY rose while BREADY low"); end
        BREADY = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (AWREADY !== 1'b1 || BVALID !== 1'b0)
            begin errors++; $display("FAIL bhold_release awready=%b bvalid=%b exp 1 0", AWREADY, BVALID); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_aw(8'd3, 11'h040, 8'd3, 3'd2, 2'b01, 4'd0);
        WVALID = 1'b1; WDATA = 32'd1; WSTRB = 4'hF; WLAST = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tgt_wr_vld !== 3'b0 || {WREADY, BVALID, busy, AWREADY} !== 4'b0)
            begin errors++; $display("FAIL rstmid_during vld=%b ctrl=%b exp 000 0000", tgt_wr_vld, {WREADY, BVALID, busy, AWREADY}); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (tgt_wr_vld !== 3'b0 || {WREADY, BVALID, busy, AWREADY} !== 4'b0 || tgt_wr_addr !== 11'h0)
            begin errors++; $display("FAIL rstmid_after vld=%b ctrl=%b addr=%h exp 000 0000 000", tgt_wr_vld, {WREADY, BVALID, busy, AWREADY}, tgt_wr_addr); end
        @(posedge clk); #1;
        rst = 1'b0; WVALID = 1'b0;
        @(negedge clk);
        checks++;
        if (AWREADY !== 1'b1 || busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_release awready=%b busy=%b exp 1 0", AWREADY, busy); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWREGION = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        tgt_wr_rdy = 3'b111; tgt_done = 3'b000; tgt_err = 3'b000;
        test_reset();
        test_incr();
        test_wrap_fixed();
        test_drain();
        test_stall_wlast();
        test_timeout_err();
        test_back_to_back_bready();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
